sprite_blitter: RTL and testbench



---
 rtl/veridog_pkg.sv | 22 ++
 rtl/sprite_blitter_raster_counter.sv | 60 ++++++
 rtl/sprite_blitter.sv | 173 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/veridog_pkg.sv
// -----------------------------------------------------------------------------
// veridog_pkg
// Shared screen geometry, default datapath widths and blitter state encoding
// for the veridog screen engines (sprite_blitter, background-fill blitter).
// -----------------------------------------------------------------------------
package veridog_pkg;

   localparam int SCREEN_W     = 160;
   localparam int SCREEN_H     = 120;

   localparam int X_W_DEF      = 8;
   localparam int Y_W_DEF      = 7;
   localparam int COLOUR_W_DEF = 9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sprite_blitter_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Row-major destination-pixel counter for an SPR_W x SPR_H source scaled by
// 1x or 2x. dx runs 0..OW-1, then dy advances; OW/OH = SPR_W/SPR_H << scale.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous return to (0,0)
//   advance     : step to the next destination pixel
//   scale       : 0 = 1x, 1 = 2x (must be stable while advancing)
//   dx, dy      : current destination pixel offset
//   last        : current pixel is (OW-1, OH-1)
// -----------------------------------------------------------------------------
module raster_counter #(
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int SPR_W = 16,
   parameter int SPR_H = 16
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           clear,
   input  logic           advance,
   input  logic           scale,
   output logic [X_W-1:0] dx,
   output logic [Y_W-1:0] dy,
   output logic           last
);

   logic [X_W-1:0] r_dx;
   logic [Y_W-1:0] r_dy;
   logic [X_W-1:0] w_x_max;
   logic [Y_W-1:0] w_y_max;
   logic           w_x_end;

   assign w_x_max = scale ? X_W'(2*SPR_W - 1) : X_W'(SPR_W - 1);
   assign w_y_max = scale ? Y_W'(2*SPR_H - 1) : Y_W'(SPR_H - 1);
   assign w_x_end = (r_dx == w_x_max);
   assign last    = w_x_end && (r_dy == w_y_max);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (clear) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (advance) begin
         if (w_x_end) begin
            r_dx <= '0;
            r_dy <= last ? '0 : r_dy + 1'b1;
         end else begin
            r_dx <= r_dx + 1'b1;
         end
      end
   end

   assign dx = r_dx;
   assign dy = r_dy;

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// Streams a SPR_W x SPR_H sprite from a synchronous ROM to the vga_adapter at
// a latched origin, with optional 2x scaling, transparent-colour skipping and
// screen-edge clipping. busy/done let several blitters share one adapter.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : blit request, sampled only in IDLE
//   xInit, yInit, scale  : origin and scale, latched on accepted start
//   romAddr / romData    : source pixel address; data returns one cycle later
//   xOut, yOut, colour   : plot coordinate and colour (held while writeEn=0)
//   writeEn              : plot strobe
//   busy                 : blit in progress (RUN and FLUSH)
//   done                 : one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int                      X_W        = veridog_pkg::X_W_DEF,
   parameter int                      Y_W        = veridog_pkg::Y_W_DEF,
   parameter int                      COLOUR_W   = veridog_pkg::COLOUR_W_DEF,
   parameter int                      SPR_W      = 16,
   parameter int                      SPR_H      = 16,
   parameter int                      ADDR_W     = 8,
   parameter int                      SCREEN_W   = veridog_pkg::SCREEN_W,
   parameter int                      SCREEN_H   = veridog_pkg::SCREEN_H,
   parameter bit                      TRANSP_EN  = 1'b1,
   parameter logic [COLOUR_W-1:0]     TRANSP_KEY = '0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [X_W-1:0]      xInit,
   input  logic [Y_W-1:0]      yInit,
   input  logic                scale,
   output logic [ADDR_W-1:0]   romAddr,
   input  logic [COLOUR_W-1:0] romData,
   output logic [X_W-1:0]      xOut,
   output logic [Y_W-1:0]      yOut,
   output logic [COLOUR_W-1:0] colour,
   output logic                writeEn,
   output logic                busy,
   output logic                done
);

   import veridog_pkg::*;

   state_t                r_state, w_next;
   logic [X_W-1:0]        r_x0;
   logic [Y_W-1:0]        r_y0;
   logic                  r_scale;

   logic [X_W-1:0]        w_dx;
   logic [Y_W-1:0]        w_dy;
   logic                  w_last;
   logic                  w_clear;
   logic                  w_adv;
   logic [X_W-1:0]        w_sx;
   logic [Y_W-1:0]        w_sy;
   logic [X_W:0]          w_px;
   logic [Y_W:0]          w_py;
   logic                  w_clip;

   logic                  r_pv;
   logic [X_W-1:0]        r_px;
   logic [Y_W-1:0]        r_py;
   logic [X_W-1:0]        r_hx;
   logic [Y_W-1:0]        r_hy;
   logic [COLOUR_W-1:0]   r_hc;
   logic                  w_transp;
   logic                  w_we;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      w_adv   = 1'b0;
      unique case (r_state)
         S_IDLE:  if (start) begin
                     w_next  = S_RUN;
                     w_clear = 1'b1;
                  end
         S_RUN:   begin
                     w_adv = 1'b1;
                     if (w_last) w_next = S_FLUSH;
                  end
         S_FLUSH: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign done = (r_state == S_DONE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x0    <= '0;
         r_y0    <= '0;
         r_scale <= 1'b0;
      end else if (w_clear) begin
         r_x0    <= xInit;
         r_y0    <= yInit;
         r_scale <= scale;
      end
   end

   // ---------------- address generation ----------------
   raster_counter #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_raster (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (w_clear),
      .advance (w_adv),
      .scale   (r_scale),
      .dx      (w_dx),
      .dy      (w_dy),
      .last    (w_last)
   );

   assign w_sx    = w_dx >> r_scale;
   assign w_sy    = w_dy >> r_scale;
   assign romAddr = ADDR_W'(w_sy) * ADDR_W'(SPR_W) + ADDR_W'(w_sx);

   // One extra bit so an origin near the edge never wraps back to column/row 0.
   assign w_px   = {1'b0, r_x0} + {1'b0, w_dx};
   assign w_py   = {1'b0, r_y0} + {1'b0, w_dy};
   assign w_clip = (w_px >= (X_W+1)'(SCREEN_W)) || (w_py >= (Y_W+1)'(SCREEN_H));

   // ---------------- plot stage ----------------
   // Coordinates are staged alongside the ROM's own output register, so the
   // strobe and colour appear in the cycle romData is valid; the hold
   // registers keep the last plotted values while the strobe is low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pv <= 1'b0;
         r_px <= '0;
         r_py <= '0;
      end else begin
         r_pv <= (r_state == S_RUN) && !w_clip;
         r_px <= w_px[X_W-1:0];
         r_py <= w_py[Y_W-1:0];
      end
   end

   assign w_transp = TRANSP_EN && (romData == TRANSP_KEY);
   assign w_we     = r_pv && !w_transp;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hx <= '0;
         r_hy <= '0;
         r_hc <= '0;
      end else if (w_we) begin
         r_hx <= r_px;
         r_hy <= r_py;
         r_hc <= romData;
      end
   end

   assign writeEn = w_we;
   assign xOut    = w_we ? r_px    : r_hx;
   assign yOut    = w_we ? r_py    : r_hy;
   assign colour  = w_we ? romData : r_hc;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Directed scoreboard bench for sprite_blitter with a 2x2 sprite. Each blit
// pushes its hand-computed strobes (x, y, colour, cycle) into a queue; a
// negedge monitor pops and compares on every writeEn and checks done timing.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       scale = 1'b0;
   logic [7:0] xInit = '0;
   logic [6:0] yInit = '0;
   logic [7:0] romAddr;
   logic [8:0] romData = '0;
   logic [7:0] xOut;
   logic [6:0] yOut;
   logic [8:0] colour;
   logic       writeEn, busy, done;

   logic [8:0] rom [0:255];

   sprite_blitter #(
      .X_W        (8),
      .Y_W        (7),
      .COLOUR_W   (9),
      .SPR_W      (2),
      .SPR_H      (2),
      .ADDR_W     (8),
      .SCREEN_W   (160),
      .SCREEN_H   (120),
      .TRANSP_EN  (1'b1),
      .TRANSP_KEY (9'h000)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .xInit   (xInit),
      .yInit   (yInit),
      .scale   (scale),
      .romAddr (romAddr),
      .romData (romData),
      .xOut    (xOut),
      .yOut    (yOut),
      .colour  (colour),
      .writeEn (writeEn),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) romData <= rom[romAddr];

   int tcyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;

   typedef struct {
      int x;
      int y;
      int c;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   t0 = 0;
   int   exp_done = -1;
   int   done_cnt = 0;
   int   last_x = 0, last_y = 0, last_c = 0;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input int x, input int y, input int c, input int cyc);
      exp_t e;
      e.x = x; e.y = y; e.c = c; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   // Monitor: strobes, held outputs and done pulses.
   always @(negedge clk) begin
      int   rel;
      exp_t e;
      rel = tcyc - t0;
      if (writeEn) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe_cycle", rel, -1);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_x", int'(xOut), e.x);
            chk("strobe_y", int'(yOut), e.y);
            chk("strobe_colour", int'(colour), e.c);
            chk("strobe_cycle", rel, e.cyc);
         end
         last_x = int'(xOut);
         last_y = int'(yOut);
         last_c = int'(colour);
      end else if (resetn) begin
         chk("hold_x", int'(xOut), last_x);
         chk("hold_y", int'(yOut), last_y);
         chk("hold_colour", int'(colour), last_c);
      end else begin
         last_x = 0; last_y = 0; last_c = 0;
      end
      if (done) begin
         done_cnt++;
         chk("done_cycle", rel, exp_done);
      end
   end

   // One blit of n output pixels; optionally re-pulses start (with a bogus
   // origin) in cycle 'repulse'. Checks busy every cycle and drains the queue.
   task automatic blit(input int x, input int y, input bit sc, input int n, input int repulse);
      @(negedge clk);
      xInit = 8'(x); yInit = 7'(y); scale = sc; start = 1'b1;
      t0 = tcyc; done_cnt = 0; exp_done = n + 2;
      for (int r = 1; r <= n + 4; r++) begin
         @(negedge clk);
         chk("busy", int'(busy), (r <= n + 1) ? 1 : 0);
         start = (r == repulse);
         if (r == repulse) begin
            xInit = 8'd99; yInit = 7'd99;
         end
      end
      start = 1'b0;
      chk("leftover_strobes", exp_q.size(), 0);
      chk("done_count", done_cnt, 1);
   endtask

   task automatic rom_default();
      rom[0] = 9'd1; rom[1] = 9'd2; rom[2] = 9'd3; rom[3] = 9'd4;
   endtask

   initial begin
      for (int unsigned i = 0; i < 256; i++) rom[i] = 9'h1FF;
      rom_default();

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_writeEn", int'(writeEn), 0);
      chk("reset_romAddr", int'(romAddr), 0);
      chk("reset_xOut", int'(xOut), 0);
      resetn = 1'b1;

      // 1x at (10,20)
      push(10, 20, 1, 2); push(11, 20, 2, 3); push(10, 21, 3, 4); push(11, 21, 4, 5);
      blit(10, 20, 1'b0, 4, -1);

      // 2x at (10,20): 4x4 output, each source pixel doubled
      for (int dy = 0; dy < 4; dy++)
         for (int dx = 0; dx < 4; dx++)
            push(10 + dx, 20 + dy, int'(rom[(dy / 2) * 2 + dx / 2]), 2 + dy * 4 + dx);
      blit(10, 20, 1'b1, 16, -1);

      // 1x clipped at bottom-right corner: only origin pixel visible
      push(159, 119, 1, 2);
      blit(159, 119, 1'b0, 4, -1);

      // 2x at (158,118): only the top-left 2x2 output quad is visible
      push(158, 118, 1, 2); push(159, 118, 1, 3); push(158, 119, 1, 6); push(159, 119, 1, 7);
      blit(158, 118, 1'b1, 16, -1);

      // 2x at (157,117): 3x3 visible, crosses a source-pixel boundary
      push(157, 117, 1, 2);  push(158, 117, 1, 3);  push(159, 117, 2, 4);
      push(157, 118, 1, 6);  push(158, 118, 1, 7);  push(159, 118, 2, 8);
      push(157, 119, 3, 10); push(158, 119, 3, 11); push(159, 119, 4, 12);
      blit(157, 117, 1'b1, 16, -1);

      // start re-pulsed in cycle 3 is ignored
      push(50, 50, 1, 2); push(51, 50, 2, 3); push(50, 51, 3, 4); push(51, 51, 4, 5);
      blit(50, 50, 1'b0, 4, 3);

      // transparent pixel skipped, timing unchanged
      rom[1] = 9'h000;
      push(10, 20, 1, 2); push(10, 21, 3, 4); push(11, 21, 4, 5);
      blit(10, 20, 1'b0, 4, -1);
      rom_default();

      // asynchronous reset in cycle 3
      @(negedge clk);
      xInit = 8'd10; yInit = 7'd20; scale = 1'b0; start = 1'b1;
      t0 = tcyc; done_cnt = 0; exp_done = -1;
      push(10, 20, 1, 2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_writeEn", int'(writeEn), 0);
      chk("async_rst_xOut", int'(xOut), 0);
      chk("async_rst_yOut", int'(yOut), 0);
      chk("async_rst_colour", int'(colour), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_romAddr", int'(romAddr), 0);
      repeat (4) @(negedge clk);
      chk("async_rst_done_count", done_cnt, 0);
      chk("async_rst_leftover", exp_q.size(), 0);
      resetn = 1'b1;

      // normal blit after reset release
      push(30, 40, 1, 2); push(31, 40, 2, 3); push(30, 41, 3, 4); push(31, 41, 4, 5);
      blit(30, 40, 1'b0, 4, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
